fixed_mult_pipe: RTL and testbench

//  Pipelined, parametrised signed fixed-point multiplier (default 1.17, 2's comp) with valid/ready flow control.

---
 rtl/fixed_mult_pipe.sv | 121 ++++++++++++
 tb/tb_fixed_mult_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_mult_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready flow control, optional rounding and overflow flag.
// Define FIXED_MULT_SAT_EN to clamp overflowed results to the most positive/negative code instead of wrapping.
module fixed_mult_pipe #(
    parameter int WIDTH  = 18,
    parameter int FRAC   = 17,
    parameter int STAGES = 2,
    parameter int ROUND  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out,
    output logic                    ovf,
    output logic                    ovf_sticky
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW:0] RND = (ROUND != 0) ? ((PW+1)'(1) << (FRAC - 1)) : '0;

    logic                 advance;
    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] fin_p;
    logic                 fin_v;
    logic [PW:0]          pr_c;
    logic [WIDTH-1:0]     wrap_c;
    logic [WIDTH-1:0]     out_d;
    logic                 ovf_d;
    logic                 unused_lsb;

    logic [WIDTH-1:0]     out_q;
    logic                 out_valid_q;
    logic                 ovf_q;
    logic                 ovf_sticky_q;

    // Every stage moves together; a stalled output freezes the whole pipe.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;
    assign prod_c   = PW'(a) * PW'(b);

    generate
        if (STAGES == 1) begin : g_direct
            assign fin_p = prod_c;
            assign fin_v = in_valid;
        end else begin : g_pipe
            logic [STAGES-2:0]    v_q;
            logic signed [PW-1:0] p_q [STAGES-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q <= '0;
                end else if (advance) begin
                    v_q[0] <= in_valid;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        v_q[i] <= v_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    p_q[0] <= prod_c;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        p_q[i] <= p_q[i-1];
                    end
                end
            end

            assign fin_p = p_q[STAGES-2];
            assign fin_v = v_q[STAGES-2];
        end
    endgenerate

    // Result fits only if every bit from the new sign position upward agrees.
    always_comb begin
        pr_c   = {fin_p[PW-1], fin_p} + RND;
        ovf_d  = !((&pr_c[PW:WIDTH+FRAC-1]) || !(|pr_c[PW:WIDTH+FRAC-1]));
        wrap_c = {pr_c[PW-1], pr_c[WIDTH+FRAC-2:FRAC]};
`ifdef FIXED_MULT_SAT_EN
        if (ovf_d) begin
            out_d = pr_c[PW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            out_d = wrap_c;
        end
`else
        out_d = wrap_c;
`endif
    end

    assign unused_lsb = ^pr_c[FRAC-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            ovf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            if (advance) begin
                out_valid_q <= fin_v;
                if (fin_v) begin
                    out_q <= out_d;
                    ovf_q <= ovf_d;
                end
            end
            if (out_valid_q && out_ready && ovf_q) begin
                ovf_sticky_q <= 1'b1;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out        = out_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Bench for fixed_mult_pipe: four configurations side by side, each scored against an arithmetic model.
module tb_fixed_mult_pipe;

    localparam int N = 4;
    localparam int WS [N] = '{18, 18, 16, 16};
    localparam int FS [N] = '{17, 17, 8, 8};
    localparam int SS [N] = '{2, 3, 1, 4};
    localparam int RS [N] = '{0, 1, 0, 1};
`ifdef FIXED_MULT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [N-1:0]  in_valid, in_ready, out_valid, out_ready, ovf, ovf_sticky;
    logic [17:0]   a_s [N];
    logic [17:0]   b_s [N];
    logic [17:0]   out_s [N];
    logic [18:0]   expq [N][$];
    logic          st_exp [N];
    logic [17:0]   ad [N];
    logic [17:0]   bd [N];
    logic [17:0]   cap [N];
    logic          capo [N];
    int            nchecks = 0;
    int            nerrors = 0;

    for (genvar k = 0; k < N; k++) begin : g_dut
        localparam int W = WS[k];
        logic [W-1:0] o;
        fixed_mult_pipe #(.WIDTH(W), .FRAC(FS[k]), .STAGES(SS[k]), .ROUND(RS[k])) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid[k]),
            .in_ready   (in_ready[k]),
            .a          (a_s[k][W-1:0]),
            .b          (b_s[k][W-1:0]),
            .out_valid  (out_valid[k]),
            .out_ready  (out_ready[k]),
            .out        (o),
            .ovf        (ovf[k]),
            .ovf_sticky (ovf_sticky[k])
        );
        assign out_s[k] = 18'(o);
    end

    function automatic logic [17:0] msk(int k);
        return 18'((64'd1 << WS[k]) - 64'd1);
    endfunction

    // Product rounded/floored to FRAC bits; overflow when it leaves the signed WIDTH range.
    function automatic logic [18:0] model(int w, int f, int r, logic [17:0] av, logic [17:0] bv);
        longint one, hi, sa, sb, pr, q, res;
        logic [63:0] rv;
        logic ov;
        one = 1;
        hi  = (one << (w - 1)) - 1;
        sa  = longint'(av) & ((one << w) - 1);
        sb  = longint'(bv) & ((one << w) - 1);
        if (sa > hi) sa = sa - (one << w);
        if (sb > hi) sb = sb - (one << w);
        pr = sa * sb;
        if (r != 0) pr = pr + (one << (f - 1));
        q  = pr >>> f;
        ov = (q > hi) || (q < -hi - 1);
        if (ov && SAT) res = (pr < 0) ? (one << (w - 1)) : hi;
        else           res = (q & hi) | ((pr < 0) ? (one << (w - 1)) : 0);
        rv = res;
        return {ov, rv[17:0]};
    endfunction

    task automatic check(string name, int k, logic [63:0] act, logic [63:0] want);
        nchecks++;
        if (act !== want) begin
            nerrors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, want);
        end
    endtask

    always @(negedge clk) begin : scoreboard
        logic [18:0] e;
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                expq[k].delete();
                st_exp[k] = 1'b0;
            end else begin
                check("sticky", k, ovf_sticky[k], st_exp[k]);
                check("in_ready", k, in_ready[k], !out_valid[k] || out_ready[k]);
                if (out_valid[k]) begin
                    if (expq[k].size() == 0) begin
                        check("spurious_out", k, out_valid[k], 0);
                    end else begin
                        e = expq[k][0];
                        check("out", k, out_s[k] & msk(k), e[17:0]);
                        check("ovf", k, ovf[k], e[18]);
                        if (out_ready[k]) begin
                            void'(expq[k].pop_front());
                            st_exp[k] = st_exp[k] | e[18];
                        end
                    end
                end
                if (in_valid[k] && in_ready[k]) begin
                    expq[k].push_back(model(WS[k], FS[k], RS[k], a_s[k], b_s[k]));
                end
            end
        end
    end

    // One operand into every pipe at once; checks out_valid rises exactly STAGES cycles later.
    task automatic shot();
        @(posedge clk); #1;
        out_ready = '1;
        for (int k = 0; k < N; k++) begin
            a_s[k] = ad[k] & msk(k);
            b_s[k] = bd[k] & msk(k);
            in_valid[k] = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                check("latency", k, out_valid[k], c == SS[k]);
                if (c == SS[k]) begin
                    cap[k]  = out_s[k] & msk(k);
                    capo[k] = ovf[k];
                end
            end
        end
    endtask

    function automatic logic [17:0] rnd_op(int k);
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return msk(k) ^ (msk(k) >> 1);
        if (sel == 1) return msk(k) >> 1;
        return 18'($urandom) & msk(k);
    endfunction

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        for (int k = 0; k < N; k++) begin
            a_s[k] = '0;
            b_s[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("rst_valid", k, out_valid[k], 0);
            check("rst_out", k, out_s[k] & msk(k), 0);
            check("rst_ovf", k, ovf[k], 0);
            check("rst_sticky", k, ovf_sticky[k], 0);
            check("rst_in_ready", k, in_ready[k], 1);
        end

        check("pin_half", 0, model(18, 17, 0, 18'h10000, 18'h10000), 19'h08000);
        check("pin_neg", 0, model(18, 17, 0, 18'h3FFFF, 18'h10000), 19'h3FFFF);
        check("pin_rnd", 1, model(18, 17, 1, 18'h00001, 18'h10000), 19'h00001);
        check("pin_w16", 2, model(16, 8, 0, 18'h00300, 18'h0FD80), 19'h0F880);

        ad = '{18'h10000, 18'h10000, 18'h0300, 18'h0300};
        bd = '{18'h10000, 18'h10000, 18'hFD80, 18'hFD80};
        shot();
        check("t1_out", 0, cap[0], 18'h08000);
        check("t1_ovf", 0, capo[0], 0);
        check("t1_out", 1, cap[1], 18'h08000);
        check("t6_out", 2, cap[2], 18'h0F880);
        check("t6_out", 3, cap[3], 18'h0F880);
        for (int k = 0; k < N; k++) check("t1_sticky", k, ovf_sticky[k], 0);

        ad = '{18'h20000, 18'h20000, 18'h8000, 18'h8000};
        bd = '{18'h20000, 18'h20000, 18'h8000, 18'h8000};
        shot();
        check("t2_out", 0, cap[0], SAT ? 18'h1FFFF : 18'h00000);
        check("t2_ovf", 0, capo[0], 1);
        check("t2_ovf", 2, capo[2], 1);
        check("t2_sticky", 0, ovf_sticky[0], 1);

        ad = '{18'h00001, 18'h00001, 18'h0001, 18'h0001};
        bd = '{18'h10000, 18'h10000, 18'h0080, 18'h0080};
        shot();
        check("t3_trunc", 0, cap[0], 18'h00000);
        check("t3_round", 1, cap[1], 18'h00001);
        check("t3_trunc", 2, cap[2], 18'h00000);
        check("t3_round", 3, cap[3], 18'h00001);

        ad = '{18'h3FFFF, 18'h3FFFF, 18'hFFFF, 18'hFFFF};
        bd = '{18'h10000, 18'h10000, 18'h0080, 18'h0080};
        shot();
        check("t3n_trunc", 0, cap[0], 18'h3FFFF);
        check("t3n_round", 1, cap[1], 18'h00000);
        check("t3n_trunc", 2, cap[2], 18'h0FFFF);
        check("t3n_round", 3, cap[3], 18'h00000);

        // Rounding carry pushes 0x7F80*0x0101 over the top only when ROUND=1.
        ad = '{18'h1FFFF, 18'h1FFFF, 18'h7F80, 18'h7F80};
        bd = '{18'h1FFFF, 18'h1FFFF, 18'h0101, 18'h0101};
        shot();
        check("t4_max", 0, cap[0], 18'h1FFFE);
        check("t4_max", 1, cap[1], 18'h1FFFE);
        check("t4_noovf", 2, capo[2], 0);
        check("t4_out", 2, cap[2], 18'h07FFF);
        check("t4_rndovf", 3, capo[3], 1);
        check("t4_out", 3, cap[3], SAT ? 18'h07FFF : 18'h00000);

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                out_ready[k] = $urandom_range(0, 1) != 0;
                a_s[k] = rnd_op(k);
                b_s[k] = rnd_op(k);
            end
        end
        @(posedge clk); #1;
        in_valid  = '0;
        out_ready = '1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) check("drain_empty", k, expq[k].size(), 0);

        ad = '{18'h10000, 18'h10000, 18'h0100, 18'h0100};
        bd = '{18'h20000, 18'h20000, 18'h8000, 18'h8000};
        @(posedge clk); #1;
        out_ready = '0;
        for (int k = 0; k < N; k++) begin
            a_s[k] = ad[k] & msk(k);
            b_s[k] = bd[k] & msk(k);
            in_valid[k] = 1'b1;
        end
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) a_s[k] = 18'h00300 & msk(k);
        @(posedge clk); #1;
        in_valid = '0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("t5_valid", k, out_valid[k], 0);
            check("t5_sticky", k, ovf_sticky[k], 0);
            check("t5_out", k, out_s[k] & msk(k), 0);
            check("t5_in_ready", k, in_ready[k], 1);
        end
        out_ready = '1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) check("t5_no_stale", k, expq[k].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
